inst_trace_buf: RTL and testbench

//   Debug/trace buffer for retired instructions. Decodes each retired instruction into a

---
 rtl/inst_trace_buf_if.sv | 27 ++
 rtl/inst_trace_buf.sv | 204 ++++++++++++++++++++
 tb/tb_inst_trace_buf.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/inst_trace_buf_if.sv
// rtl/inst_trace_buf_if.sv - retire-side input and trace read-side bundle for inst_trace_buf
interface inst_trace_buf_if #(
    parameter int NCHARS = 6,
    parameter int DEPTH  = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [31:0]           in_pc;
    logic [31:0]           in_instr;
    logic                  rd_en;
    logic                  rd_valid;
    logic [31:0]           rd_pc;
    logic [31:0]           rd_instr;
    logic [8*NCHARS-1:0]   rd_ascii;
    logic [LW-1:0]         level;

    modport master (
        output in_valid, in_pc, in_instr, rd_en,
        input  rd_valid, rd_pc, rd_instr, rd_ascii, level
    );

    modport slave (
        input  in_valid, in_pc, in_instr, rd_en,
        output rd_valid, rd_pc, rd_instr, rd_ascii, level
    );
endinterface

// File: rtl/inst_trace_buf.sv
// rtl/inst_trace_buf.sv - retired-instruction trace ring FIFO with mnemonic decode and class counters
module inst_trace_buf #(
    parameter int NCHARS = 6,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    inst_trace_buf_if.slave  bus,
    input  logic             freeze,
    input  logic             flush,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_alu,
    output logic [CNT_W-1:0] cnt_mem,
    output logic [CNT_W-1:0] cnt_br,
    output logic [CNT_W-1:0] cnt_oth,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int W  = 8 * NCHARS;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {C_ALU, C_MEM, C_BR, C_OTH} cls_t;

    logic [31:0] ins;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt;
    logic [63:0] dec_m;
    cls_t        dec_c;

    assign ins   = bus.in_instr;
    assign op    = ins[31:26];
    assign rs    = ins[25:21];
    assign rt    = ins[20:16];
    assign funct = ins[5:0];

    always_comb begin
        dec_m = "N-R";
        dec_c = C_OTH;
        if (ins == 32'h0) begin
            dec_m = "NOP";
        end else begin
            case (op)
                6'h00: begin
                    dec_c = C_ALU;
                    case (funct)
                        6'h24: dec_m = "AND";
                        6'h25: dec_m = "OR";
                        6'h26: dec_m = "XOR";
                        6'h27: dec_m = "NOR";
                        6'h00: dec_m = "SLL";
                        6'h02: dec_m = "SRL";
                        6'h03: dec_m = "SRA";
                        6'h04: dec_m = "SLLV";
                        6'h06: dec_m = "SRLV";
                        6'h07: dec_m = "SRAV";
                        6'h10: dec_m = "MFHI";
                        6'h11: dec_m = "MTHI";
                        6'h12: dec_m = "MFLO";
                        6'h13: dec_m = "MTLO";
                        6'h20: dec_m = "ADD";
                        6'h21: dec_m = "ADDU";
                        6'h22: dec_m = "SUB";
                        6'h23: dec_m = "SUBU";
                        6'h2A: dec_m = "SLT";
                        6'h2B: dec_m = "SLTU";
                        6'h18: dec_m = "MULT";
                        6'h19: dec_m = "MULTU";
                        6'h1A: dec_m = "DIV";
                        6'h1B: dec_m = "DIVU";
                        6'h08: begin dec_m = "JR";   dec_c = C_BR;  end
                        6'h09: begin dec_m = "JALR"; dec_c = C_BR;  end
                        6'h0C: begin dec_m = "SYSC"; dec_c = C_OTH; end
                        6'h0D: begin dec_m = "BRE";  dec_c = C_OTH; end
                        default: dec_c = C_OTH;
                    endcase
                end
                6'h0C: begin dec_m = "ANDI";  dec_c = C_ALU; end
                6'h0E: begin dec_m = "XORI";  dec_c = C_ALU; end
                6'h0F: begin dec_m = "LUI";   dec_c = C_ALU; end
                6'h0D: begin dec_m = "ORI";   dec_c = C_ALU; end
                6'h08: begin dec_m = "ADDI";  dec_c = C_ALU; end
                6'h09: begin dec_m = "ADDIU"; dec_c = C_ALU; end
                6'h0A: begin dec_m = "SLTI";  dec_c = C_ALU; end
                6'h0B: begin dec_m = "SLTIU"; dec_c = C_ALU; end
                6'h02: begin dec_m = "J";     dec_c = C_BR;  end
                6'h03: begin dec_m = "JAL";   dec_c = C_BR;  end
                6'h04: begin dec_m = "BEQ";   dec_c = C_BR;  end
                6'h05: begin dec_m = "BNE";   dec_c = C_BR;  end
                6'h07: begin dec_m = "BGTZ";  dec_c = C_BR;  end
                6'h06: begin dec_m = "BLEZ";  dec_c = C_BR;  end
                6'h01: begin
                    case (rt)
                        5'h01: begin dec_m = "BGEZ";   dec_c = C_BR; end
                        5'h11: begin dec_m = "BGEZAL"; dec_c = C_BR; end
                        5'h00: begin dec_m = "BLTZ";   dec_c = C_BR; end
                        5'h10: begin dec_m = "BLTZAL"; dec_c = C_BR; end
                        default: ;
                    endcase
                end
                6'h20: begin dec_m = "LB";  dec_c = C_MEM; end
                6'h24: begin dec_m = "LBU"; dec_c = C_MEM; end
                6'h21: begin dec_m = "LH";  dec_c = C_MEM; end
                6'h25: begin dec_m = "LHU"; dec_c = C_MEM; end
                6'h23: begin dec_m = "LW";  dec_c = C_MEM; end
                6'h28: begin dec_m = "SB";  dec_c = C_MEM; end
                6'h29: begin dec_m = "SH";  dec_c = C_MEM; end
                6'h2B: begin dec_m = "SW";  dec_c = C_MEM; end
                6'h10: begin
                    if (ins == 32'h42000018) dec_m = "ERET";
                    else if (rs == 5'd0)     dec_m = "MFC0";
                    else if (rs == 5'd4)     dec_m = "MTC0";
                end
                default: ;
            endcase
        end
    end

    logic          acc;
    logic          stg_valid;
    logic [31:0]   stg_pc, stg_instr;
    logic [W-1:0]  stg_ascii;

    assign acc = bus.in_valid & ~freeze & ~flush;

    // Size cast keeps the rightmost NCHARS characters of the right-justified literal.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid <= 1'b0;
            stg_pc    <= '0;
            stg_instr <= '0;
            stg_ascii <= '0;
        end else begin
            stg_valid <= acc;
            if (acc) begin
                stg_pc    <= bus.in_pc;
                stg_instr <= bus.in_instr;
                stg_ascii <= W'(dec_m);
            end
        end
    end

    logic [LW-1:0] wr_ptr, rd_ptr, level_i;
    logic          wr, full, empty, pop, drop;
    logic [31:0]   mem_pc    [DEPTH];
    logic [31:0]   mem_instr [DEPTH];
    logic [W-1:0]  mem_ascii [DEPTH];

    assign wr      = stg_valid & ~flush;
    assign level_i = wr_ptr - rd_ptr;
    assign full    = (level_i == LW'(DEPTH));
    assign empty   = (level_i == '0);
    assign pop     = bus.rd_en & ~empty;
    assign drop    = wr & full & ~pop;

    // A write into a full FIFO without a pop pushes the head forward over the oldest entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr)          wr_ptr <= wr_ptr + LW'(1);
            if (pop || drop) rd_ptr <= rd_ptr + LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem_pc[wr_ptr[AW-1:0]]    <= stg_pc;
            mem_instr[wr_ptr[AW-1:0]] <= stg_instr;
            mem_ascii[wr_ptr[AW-1:0]] <= stg_ascii;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr_cnt) begin
            cnt_alu  <= '0;
            cnt_mem  <= '0;
            cnt_br   <= '0;
            cnt_oth  <= '0;
            drop_cnt <= '0;
        end else begin
            if (acc) begin
                case (dec_c)
                    C_ALU: if (cnt_alu != '1) cnt_alu <= cnt_alu + CNT_W'(1);
                    C_MEM: if (cnt_mem != '1) cnt_mem <= cnt_mem + CNT_W'(1);
                    C_BR:  if (cnt_br  != '1) cnt_br  <= cnt_br  + CNT_W'(1);
                    default: if (cnt_oth != '1) cnt_oth <= cnt_oth + CNT_W'(1);
                endcase
            end
            if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

    // Memory is not reset, so the read port is gated to keep outputs zero while empty.
    assign bus.rd_valid = ~empty;
    assign bus.level    = level_i;
    assign bus.rd_pc    = empty ? '0 : mem_pc[rd_ptr[AW-1:0]];
    assign bus.rd_instr = empty ? '0 : mem_instr[rd_ptr[AW-1:0]];
    assign bus.rd_ascii = empty ? '0 : mem_ascii[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_inst_trace_buf.sv
// tb/tb_inst_trace_buf.sv - scoreboard bench for inst_trace_buf
module tb_inst_trace_buf;
    localparam int NCHARS = 6;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 4;

    localparam logic [31:0] I_ADDU = 32'h00851021;
    localparam logic [31:0] I_ORI  = 32'h34A50001;

    logic clk, rst, freeze, flush, clr_cnt;
    logic [CNT_W-1:0] cnt_alu, cnt_mem, cnt_br, cnt_oth, drop_cnt;

    inst_trace_buf_if #(.NCHARS(NCHARS), .DEPTH(DEPTH)) bus ();

    inst_trace_buf #(.NCHARS(NCHARS), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .freeze(freeze), .flush(flush), .clr_cnt(clr_cnt),
        .cnt_alu(cnt_alu), .cnt_mem(cnt_mem), .cnt_br(cnt_br),
        .cnt_oth(cnt_oth), .drop_cnt(drop_cnt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [47:0] asc;
    } ent_t;

    ent_t exp_q[$];
    int   tests  = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && bus.rd_valid && bus.rd_en) begin
            ent_t e;
            tests++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got pc=%h instr=%h ascii=%h required no entry",
                         bus.rd_pc, bus.rd_instr, bus.rd_ascii);
            end else begin
                e = exp_q.pop_front();
                if ({bus.rd_pc, bus.rd_instr, bus.rd_ascii} !== e) begin
                    errors++;
                    $display("FAIL pop_entry: got pc=%h instr=%h ascii=%h required pc=%h instr=%h ascii=%h",
                             bus.rd_pc, bus.rd_instr, bus.rd_ascii, e.pc, e.instr, e.asc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input logic [47:0] asc);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = ins;
        exp_q.push_back('{pc, ins, asc});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        repeat (n) step();
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_cnt = 1'b1;
        step();
        clr_cnt = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.rd_en = 1'b0;
        repeat (2) step();
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_rd_pc", bus.rd_pc, 32'd0);
        chk("rst_counters", {cnt_alu, cnt_mem, cnt_br, cnt_oth, drop_cnt}, 32'd0);
        rst = 1'b0;

        issue(32'hBFC00000, 32'h0, "NOP");
        chk("nop_cnt_oth", 32'(cnt_oth), 32'd1);
        chk("nop_level_n1", 32'(bus.level), 32'd0);
        step();
        chk("nop_rd_valid", 32'(bus.rd_valid), 32'd1);
        chk("nop_level", 32'(bus.level), 32'd1);
        pop_n(1);
        chk("nop_level_after_pop", 32'(bus.level), 32'd0);

        pulse_clr();
        issue(32'h00400000, I_ADDU,       "ADDU");
        issue(32'h00400004, 32'h8C820004, "LW");
        issue(32'h00400008, 32'h10850003, "BEQ");
        issue(32'h0040000C, 32'h42000018, "ERET");
        step();
        chk("stream_level", 32'(bus.level), 32'd4);
        chk("stream_counts", {cnt_alu, cnt_mem, cnt_br, cnt_oth}, 32'h1111);
        pop_n(4);

        pulse_clr();
        issue(32'h00500000, 32'h04100003, "BLTZAL");
        issue(32'h00500004, 32'h40086000, "MFC0");
        issue(32'h00500008, 32'h40886000, "MTC0");
        issue(32'h0050000C, 32'hFC000000, "N-R");
        issue(32'h00500010, 32'hAC820000, "SW");
        issue(32'h00500014, 32'h00850019, "MULTU");
        issue(32'h00500018, 32'h3C011234, "LUI");
        step();
        chk("decode_level", 32'(bus.level), 32'd7);
        chk("decode_counts", {cnt_alu, cnt_mem, cnt_br, cnt_oth}, 32'h2113);
        pop_n(7);

        pulse_clr();
        for (int i = 0; i < 20; i++) issue(32'h1000 + 32'(4 * i), I_ADDU, "ADDU");
        step();
        repeat (4) void'(exp_q.pop_front());
        chk("ovf_level", 32'(bus.level), 32'd16);
        chk("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        chk("sat_cnt_alu", 32'(cnt_alu), 32'd15);
        chk("ovf_head_pc", bus.rd_pc, 32'h1010);

        for (int k = 0; k <= 8; k++) begin
            bus.in_valid = (k < 8);
            bus.in_pc    = 32'h2000 + 32'(4 * k);
            bus.in_instr = I_ORI;
            if (k < 8) exp_q.push_back('{32'h2000 + 32'(4 * k), I_ORI, 48'("ORI")});
            bus.rd_en = (k >= 1);
            step();
            if (k >= 2) chk("fullpop_level", 32'(bus.level), 32'd16);
        end
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b0;
        chk("fullpop_drop_cnt", 32'(drop_cnt), 32'd4);

        pulse_clr();
        chk("clr_cnt_alu", 32'(cnt_alu), 32'd0);
        chk("clr_drop_cnt", 32'(drop_cnt), 32'd0);
        pop_n(16);
        pop_n(2);
        chk("drain_level", 32'(bus.level), 32'd0);

        for (int i = 0; i < 3; i++) issue(32'h3000 + 32'(4 * i), I_ADDU, "ADDU");
        bus.in_valid = 1'b1;
        bus.in_pc    = 32'h300C;
        bus.in_instr = I_ADDU;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        chk("flush_level", 32'(bus.level), 32'd0);
        chk("flush_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("flush_cnt_alu", 32'(cnt_alu), 32'd3);
        repeat (3) step();
        chk("flush_level_later", 32'(bus.level), 32'd0);

        freeze = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h8C820004;
        repeat (3) step();
        bus.in_valid = 1'b0;
        freeze = 1'b0;
        repeat (2) step();
        chk("freeze_level", 32'(bus.level), 32'd0);
        chk("freeze_counts", {cnt_alu, cnt_mem, cnt_br, cnt_oth}, 32'h3000);

        bus.rd_en = 1'b1;
        clr_cnt = 1'b1;
        issue(32'h4000, I_ADDU, "ADDU");
        clr_cnt = 1'b0;
        chk("clr_beats_inc", 32'(cnt_alu), 32'd0);
        step();
        bus.rd_en = 1'b0;
        chk("empty_rden_level", 32'(bus.level), 32'd1);
        pop_n(1);

        issue(32'h5000, I_ADDU, "ADDU");
        issue(32'h5004, I_ADDU, "ADDU");
        step();
        chk("pre_rst_level", 32'(bus.level), 32'd2);
        #3;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("async_rst_level", 32'(bus.level), 32'd0);
        chk("async_rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("async_rst_cnt_alu", 32'(cnt_alu), 32'd0);
        step();
        rst = 1'b0;
        step();

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
